// File: rtl/calyx_math_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calyx_math_pkg : shared types and helpers for the fixed-point math  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package calyx_math_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fp_div_state_t;

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int unsigned fp_div_cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_div_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_div_step : one restoring-division compare/subtract/shift step    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module fp_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [WIDTH-1:0] quot_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  // The trial value is one bit wider than the divisor so the compare cannot overflow.
  logic [WIDTH:0] trial;
  logic           fits;

  always_comb begin
    trial  = {rem_i, bit_i};
    fits   = (trial >= {1'b0, divisor_i});
    rem_o  = fits ? WIDTH'(trial - {1'b0, divisor_i}) : trial[WIDTH-1:0];
    quot_o = WIDTH'({quot_i, fits});
  end

endmodule
`default_nettype wire

// File: rtl/fp_div_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_div_seq : sequential unsigned fixed-point restoring divider      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module fp_div_seq
  import calyx_math_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             div_by_zero,
  output logic             done
);

  localparam int            ITERATIONS = WIDTH + FRAC_WIDTH;
  localparam int            CW         = fp_div_cnt_width(ITERATIONS);
  localparam logic [CW-1:0] LAST       = CW'(ITERATIONS - 1);

  if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_cfg
    $error("fp_div_seq: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
  end

  fp_div_state_t           state_q;
  logic [CW-1:0]           cnt_q;
  logic [ITERATIONS-1:0]   dvd_q;
  logic [WIDTH-1:0]        rhs_q;
  logic [WIDTH-1:0]        rem_q;
  logic [WIDTH-1:0]        quot_q;
  logic [WIDTH-1:0]        step_rem_d;
  logic [WIDTH-1:0]        step_quot_d;

  fp_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[ITERATIONS-1]),
    .divisor_i (rhs_q),
    .quot_i    (quot_q),
    .rem_o     (step_rem_d),
    .quot_o    (step_quot_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dvd_q         <= '0;
      rhs_q         <= '0;
      rem_q         <= '0;
      quot_q        <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      div_by_zero   <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go) begin
            // Dividend is left scaled by 2^FRAC_WIDTH; bits leave MSB first.
            dvd_q  <= ITERATIONS'(left) << FRAC_WIDTH;
            rhs_q  <= right;
            rem_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            if (right == '0) begin
              out_quotient  <= '1;
              out_remainder <= left;
              div_by_zero   <= 1'b1;
              state_q       <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q  <= step_rem_d;
          quot_q <= step_quot_d;
          dvd_q  <= dvd_q << 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            out_quotient  <= step_quot_d;
            out_remainder <= step_rem_d;
            div_by_zero   <= 1'b0;
            state_q       <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
